// File: rtl/fpna_cfg_pkg.sv
// Shared types and default sizes for the FPNA configuration loader.
// Optional feature macro: CFG_READBACK_EN (readback verify pass).
package fpna_cfg_pkg;

  localparam int unsigned DEF_CHAIN_LEN = 10;
  localparam int unsigned DEF_WORD_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT,
    VERIFY,
    DONE
  } state_t;

endpackage

// File: rtl/fpna_cfg_loader_if.sv
// Host word stream into the loader: valid/ready handshake plus data.
// Optional feature macro: CFG_READBACK_EN (does not change this interface).
interface fpna_cfg_loader_if
  import fpna_cfg_pkg::*;
#(
  parameter int unsigned WORD_W = DEF_WORD_W
);

  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/fpna_cfg_piso.sv
// Parallel-in serial-out word register with a count of bits left in the word.
// Optional feature macro: CFG_READBACK_EN (does not change this block).
module fpna_cfg_piso #(
  parameter  int unsigned WORD_W = 8,
  localparam int unsigned CNT_W  = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] load_word,
  input  logic [CNT_W-1:0]  load_cnt,
  output logic              next_bit_c,
  output logic              last_c
);

  logic [WORD_W-1:0] word_q;
  logic [CNT_W-1:0]  cnt_q;

  // Bit that reaches the MSB after one more shift.
  if (WORD_W > 1) begin : g_wide
    assign next_bit_c = word_q[WORD_W-2];
  end else begin : g_narrow
    assign next_bit_c = 1'b0;
  end

  assign last_c = (cnt_q == CNT_W'(1));

  // Load a host word or shift it out MSB first, counting down bits left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      word_q <= load_word;
      cnt_q  <= load_cnt;
    end else if (shift) begin
      word_q <= word_q << 1;
      cnt_q  <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/fpna_cfg_loader.sv
// Streams host config words into a serial configuration chain, MSB first.
// Optional feature macro: CFG_READBACK_EN -- after shifting, re-sends the
// frame from a history register and flags any bs_out mismatch on err.
module fpna_cfg_loader
  import fpna_cfg_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int unsigned WORD_W    = DEF_WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  fpna_cfg_loader_if.slave host,
  output logic             cfg_en,
  output logic             cfg_bs,
  input  logic             cfg_ret,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned FRAME_W = $clog2(CHAIN_LEN + 1);
  localparam int unsigned CNT_W   = $clog2(WORD_W + 1);

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               load, shift, next_bit, word_last;
  logic [CNT_W-1:0]   load_cnt;
  logic               cfg_bs_d;
`ifdef CFG_READBACK_EN
  logic [CHAIN_LEN-1:0] hist_q, hist_d;
  logic                 err_q, err_d;
`endif

  fpna_cfg_piso #(.WORD_W(WORD_W)) u_piso (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .shift      (shift),
    .load_word  (host.in_data),
    .load_cnt   (load_cnt),
    .next_bit_c (next_bit),
    .last_c     (word_last)
  );

  // Next state, counters and the next serial bit.
  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    load     = 1'b0;
    shift    = 1'b0;
    load_cnt = '0;
    cfg_bs_d = 1'b0;
`ifdef CFG_READBACK_EN
    hist_d   = hist_q;
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          frame_d = FRAME_W'(CHAIN_LEN);
`ifdef CFG_READBACK_EN
          err_d   = 1'b0;
`endif
        end
      end
      FETCH: begin
        if (host.in_valid && host.in_ready) begin
          load     = 1'b1;
          // The final word may carry more bits than the frame still needs.
          load_cnt = (32'(frame_q) >= WORD_W) ? CNT_W'(WORD_W) : CNT_W'(frame_q);
          cfg_bs_d = host.in_data[WORD_W-1];
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        shift   = 1'b1;
        frame_d = frame_q - FRAME_W'(1);
`ifdef CFG_READBACK_EN
        hist_d  = {hist_q[CHAIN_LEN-2:0], cfg_bs};
`endif
        if (!word_last) begin
          cfg_bs_d = next_bit;
        end else if (frame_q != FRAME_W'(1)) begin
          state_d = FETCH;
        end else begin
`ifdef CFG_READBACK_EN
          state_d  = VERIFY;
          frame_d  = FRAME_W'(CHAIN_LEN);
          cfg_bs_d = hist_d[CHAIN_LEN-1];
`else
          state_d  = DONE;
`endif
        end
      end
`ifdef CFG_READBACK_EN
      VERIFY: begin
        // Rotating the history re-sends the frame, leaving the chain intact.
        frame_d = frame_q - FRAME_W'(1);
        hist_d  = {hist_q[CHAIN_LEN-2:0], hist_q[CHAIN_LEN-1]};
        if (cfg_ret != cfg_bs) begin
          err_d = 1'b1;
        end
        if (frame_q == FRAME_W'(1)) begin
          state_d = DONE;
        end else begin
          cfg_bs_d = hist_d[CHAIN_LEN-1];
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, frame counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      frame_q       <= '0;
      host.in_ready <= 1'b0;
      cfg_en        <= 1'b0;
      cfg_bs        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_q       <= frame_d;
      host.in_ready <= (state_d == FETCH);
      cfg_en        <= (state_d == SHIFT) || (state_d == VERIFY);
      cfg_bs        <= cfg_bs_d;
      busy          <= (state_d == FETCH) || (state_d == SHIFT) || (state_d == VERIFY);
      done          <= (state_d == DONE);
    end
  end

`ifdef CFG_READBACK_EN
  // History of sent bits and sticky readback error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      err_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_ret;
  assign unused_ret = cfg_ret;
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_fpna_cfg_loader.sv
// Randomized self-checking bench for fpna_cfg_loader with a chain model.
// Honours CFG_READBACK_EN when the design is built with it.
`timescale 1ns/1ps
module tb_fpna_cfg_loader;

  localparam int unsigned L  = 10;
  localparam int unsigned W  = 8;
  localparam int unsigned NW = (L + W - 1) / W;
`ifdef CFG_READBACK_EN
  localparam int unsigned EXP_SENT = 2 * L;
`else
  localparam int unsigned EXP_SENT = L;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic cfg_en, cfg_bs, cfg_ret, busy, done, err;
  logic [L-1:0] chain;
  bit stuck;

  fpna_cfg_loader_if #(.WORD_W(W)) hif ();

  fpna_cfg_loader #(.CHAIN_LEN(L), .WORD_W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .host    (hif),
    .cfg_en  (cfg_en),
    .cfg_bs  (cfg_bs),
    .cfg_ret (cfg_ret),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Target chain: plain shift register, output optionally stuck at 0.
  always @(posedge clk) if (cfg_en) chain <= {chain[L-2:0], cfg_bs};
  assign cfg_ret = stuck ? 1'b0 : chain[L-1];

  logic [W-1:0]    words [NW];
  logic [L-1:0]    exp_chain, exp_sh;
  logic [NW*W-1:0] stream;
  bit              exp_err, prev_done;
  int              sent_cnt, done_cnt, gap;
  int              n_cmp = 0, n_bad = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Frame = words concatenated MSB first, truncated to the first L bits.
  function automatic void build_model();
    stream = '0;
    for (int k = 0; k < NW; k++) stream = (stream << W) | (NW*W)'(words[k]);
    exp_chain = stream[NW*W-1 -: L];
    exp_err = stuck && (exp_chain != '0);
`ifndef CFG_READBACK_EN
    exp_err = 1'b0;
`endif
  endfunction

  // Per-cycle compare against the expected bit stream and frame outcome.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs", 32'({hif.in_ready, cfg_en, cfg_bs, busy, done, err}), 32'd0);
      prev_done = 1'b0;
    end else begin
      if (cfg_en) begin
        chk("en_while_busy", 32'(busy), 32'd1);
        chk("en_ready_excl", 32'(hif.in_ready), 32'd0);
        chk("sent_in_range", 32'(sent_cnt < int'(EXP_SENT)), 32'd1);
        chk("cfg_bs", 32'(cfg_bs), 32'(exp_sh[L-1]));
        exp_sh = {exp_sh[L-2:0], exp_sh[L-1]};
        sent_cnt++;
      end else begin
        chk("bs_zero_idle", 32'(cfg_bs), 32'd0);
        if (busy && sent_cnt == int'(W)) gap++;
      end
      if (hif.in_ready) chk("ready_busy", 32'(busy), 32'd1);
      if (done) begin
        chk("done_not_busy", 32'(busy), 32'd0);
        chk("done_one_cycle", 32'(prev_done), 32'd0);
        chk("shift_count", 32'(sent_cnt), 32'(EXP_SENT));
        chk("chain_content", 32'(chain), 32'(exp_chain));
        chk("err_at_done", 32'(err), 32'(exp_err));
        done_cnt++;
      end
      prev_done = done;
    end
  end

  task automatic run_frame(input int stall_max, input bit rnd_stall, input bit poke, input int abort_at);
    int t, stall;
    build_model();
    sent_cnt = 0; done_cnt = 0; gap = 0; exp_sh = exp_chain;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_ready", 32'(hif.in_ready), 32'd1);
    chk("start_err_clear", 32'(err), 32'd0);
    for (int k = 0; k < NW; k++) begin
      t = 0;
      while (!hif.in_ready && t < 100) begin
        hif.in_valid = 1'($urandom);
        hif.in_data  = W'($urandom);
        start = poke & busy & 1'($urandom);
        @(posedge clk); #1; t++;
      end
      start = 1'b0;
      if (!hif.in_ready) begin
        chk("fetch_timeout", 32'(t), 32'd0);
        return;
      end
      hif.in_valid = 1'b0;
      stall = rnd_stall ? int'($urandom_range(0, stall_max)) : stall_max;
      repeat (stall) begin @(posedge clk); #1; end
      hif.in_valid = 1'b1;
      hif.in_data  = words[k];
      @(posedge clk); #1;
      hif.in_valid = 1'b0;
      hif.in_data  = W'($urandom);
      if (abort_at > 0) begin
        t = 0;
        while (sent_cnt < abort_at && t < 100) begin @(negedge clk); t++; end
        #2 rst_n = 1'b0;
        #1;
        chk("abort_cfg_en", 32'(cfg_en), 32'd0);
        chk("abort_in_ready", 32'(hif.in_ready), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        return;
      end
    end
    t = 0;
    while (done_cnt == 0 && t < 200) begin
      start = poke & (busy | done) & 1'($urandom);
      @(posedge clk); #1; t++;
    end
    start = 1'b0;
    if (done_cnt == 0) chk("done_timeout", 32'(t), 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("idle_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    hif.in_valid = 1'b0;
    hif.in_data  = '0;
    stuck = 1'b0;
    chain = '0;
    #1 rst_n = 1'b0;
    #1 chk("reset_state", 32'({hif.in_ready, cfg_en, cfg_bs, busy, done, err}), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Back-to-back words 0xA5, 0xC0.
    words[0] = 8'hA5; words[1] = 8'hC0;
    run_frame(0, 1'b0, 1'b0, 0);
    chk("model_pin", 32'(exp_chain), 32'b1010010111);
    chk("a5c0_chain", 32'(chain), 32'b1010010111);
    chk("a5c0_gap", 32'(gap), 32'd1);
    chk("a5c0_shifts", 32'(sent_cnt), 32'(EXP_SENT));

    // Host stalls in FETCH: gap widens, content identical.
    run_frame(2, 1'b0, 1'b0, 0);
    chk("stall_gap", 32'(gap), 32'd3);
    chk("stall_chain", 32'(chain), 32'b1010010111);

    // Start pulsed while busy is ignored.
    words[0] = W'($urandom); words[1] = W'($urandom);
    run_frame(1, 1'b1, 1'b1, 0);

    // Reset mid-shift, then a full frame from scratch.
    run_frame(0, 1'b0, 1'b0, 4);
    words[0] = 8'hA5; words[1] = 8'hC0;
    run_frame(0, 1'b0, 1'b0, 0);
    chk("post_reset_chain", 32'(chain), 32'b1010010111);

`ifdef CFG_READBACK_EN
    stuck = 1'b1;
    run_frame(0, 1'b0, 1'b0, 0);
    chk("stuck_err", 32'(err), 32'd1);
    stuck = 1'b0;
    run_frame(0, 1'b0, 1'b0, 0);
    chk("err_cleared", 32'(err), 32'd0);
`endif

    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < NW; k++) words[k] = W'($urandom);
      run_frame(3, 1'b1, 1'($urandom), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    n_bad++;
    $display("FAIL watchdog: simulation did not finish, limit 400000 ns reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fpna_cfg_loader.md
FPNA_CFG_LOADER -- requirements
Module: fpna_cfg_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 10, number of bits in the target configuration shift chain (>=2).
REQ-002 SHALL have parameter WORD_W, default 8, width of host config words (>=1).
REQ-003 SHALL have port clk input 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n input 1: asynchronous active-low reset.
REQ-005 SHALL have port start input 1: one-cycle request to program one frame; ignored unless IDLE.
REQ-006 SHALL have port in_data input WORD_W: config word, MSB shifted first.
REQ-007 SHALL have port in_valid input 1: host word valid.
REQ-008 SHALL have port in_ready output 1: loader accepts a word on a cycle where in_valid and in_ready are both high.
REQ-009 SHALL have port cfg_en output 1: chain shift enable; drives the chain's config_en.
REQ-010 SHALL have port cfg_bs output 1: serial bit to the chain's bs_in.
REQ-011 SHALL have port cfg_ret input 1: chain's serial output bs_out.
REQ-012 SHALL have port busy output 1: high in FETCH, SHIFT, VERIFY.
REQ-013 SHALL have port done output 1: one-cycle pulse at frame completion.
REQ-014 SHALL have port err output 1: sticky readback mismatch flag.

Function
REQ-015 SHALL implement states IDLE, FETCH, SHIFT, VERIFY, DONE.
REQ-016 SHALL move IDLE->FETCH on the edge where start=1; frame bit counter loads CHAIN_LEN, err clears.
REQ-017 SHALL assert in_ready only in FETCH; on handshake, capture in_data, set word bit counter to min(WORD_W, remaining frame bits), enter SHIFT.
REQ-018 SHALL in SHIFT drive cfg_en=1 and cfg_bs=current word MSB each cycle, shift word left, decrement both counters.
REQ-019 SHALL leave SHIFT after the last word bit: to FETCH if frame bits remain, else to VERIFY (macro on) or DONE (macro off).
REQ-020 SHALL discard unused low bits of the final word when CHAIN_LEN is not a multiple of WORD_W; words per frame = ceil(CHAIN_LEN/WORD_W).
REQ-021 SHALL drive cfg_en=0 and cfg_bs=0 outside SHIFT and VERIFY; host stalls in FETCH insert cfg_en-low gaps and lose no bits.
REQ-022 SHALL hold DONE exactly one cycle with done=1, then return to IDLE; start in DONE is ignored.
REQ-023 SHALL ignore start and in_valid in every state where they are not consumed.

Reset
REQ-024 SHALL on rst_n low immediately force IDLE, in_ready=0, cfg_en=0, cfg_bs=0, busy=0, done=0, err=0, counters and word register 0, including mid-frame.

Configuration
REQ-025 SHALL, with CFG_READBACK_EN defined, keep a CHAIN_LEN-bit history of sent bits and run VERIFY for CHAIN_LEN cycles, re-sending history bit i (first-sent first) with cfg_en=1 while comparing cfg_ret to that bit each cycle; any mismatch sets err, and chain contents end unchanged.
REQ-026 SHALL, without CFG_READBACK_EN, omit the history register and VERIFY state, go SHIFT->DONE, and tie err to 0.

Structure
REQ-027 SHALL put the state enum and default CHAIN_LEN/WORD_W constants in shared package fpna_cfg_pkg.
REQ-028 SHALL place the word register and word bit counter in sub-module fpna_cfg_piso (parallel-in serial-out, load/shift/empty).

Verification
REQ-029 SHALL test CHAIN_LEN=10, WORD_W=8, words 0xA5, 0xC0 back-to-back -> 10 cfg_en cycles, cfg_bs stream 1010010111, chain model holds 10'b1010010111, one done pulse.
REQ-030 SHALL test second word delayed 3 cycles -> 3-cycle cfg_en gap after bit 8, identical final chain content.
REQ-031 SHALL test with CFG_READBACK_EN and correct chain model -> 10 VERIFY cycles, err=0, chain content unchanged, done after VERIFY.
REQ-032 SHALL test with CFG_READBACK_EN and chain model with its output stuck at 0 -> err=1 after done, cleared by next start.
REQ-033 SHALL test rst_n low in mid-SHIFT (bit 4) -> cfg_en, in_ready, busy 0 in the same cycle; a new start then programs a full frame correctly.
REQ-034 SHALL test start pulsed during SHIFT -> ignored, exactly one done and 10 shifts.
